// File: rtl/isqrt_seq_pkg.sv
// Shared definitions for the sequential integer square root: FSM encoding,
// default widths and the derived root width.
package isqrt_seq_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Default widths, named after the BW_* widths used by the downstream mult.
  localparam int BW_RAD_DEF = 8;
  localparam int BW_CNT_DEF = 3;

  // The root carries half as many bits as the radicand.
  function automatic int bw_root(input int bw_rad);
    return bw_rad / 2;
  endfunction

endpackage

// File: rtl/isqrt_step.sv
// One radix-2 digit-by-digit square-root iteration: consumes two radicand bits
// and produces the next partial root and partial remainder.
module isqrt_step
  import isqrt_seq_pkg::*;
#(
  parameter int BW_RAD = BW_RAD_DEF
) (
  input  logic [bw_root(BW_RAD):0]   r,
  input  logic [bw_root(BW_RAD)-1:0] q,
  input  logic [1:0]                 rad_bits,
  output logic [bw_root(BW_RAD):0]   r_nxt,
  output logic [bw_root(BW_RAD)-1:0] q_nxt
);

  localparam int N  = bw_root(BW_RAD);
  localparam int W2 = N + 2;
  localparam int RW = N + 1;

  logic [W2-1:0] r2;
  logic [W2-1:0] t;
  logic          ge;

  // Before any step r <= 2*q < 2^N, so the bit dropped from {r, rad_bits} is
  // always zero and the trial compare stays exact in N+2 bits.
  always_comb begin
    r2 = W2'({r, rad_bits});
    t  = W2'({q, 2'b01});
    ge = (r2 >= t);
    if (ge) begin
      r_nxt = RW'(r2 - t);
    end else begin
      r_nxt = RW'(r2);
    end
    q_nxt    = q << 1;
    q_nxt[0] = ge;
  end

endmodule

// File: rtl/isqrt_seq.sv
// Sequential unsigned integer square root, one root bit per clock, with the
// same start/busy/done handshake as the downstream multiplier.
module isqrt_seq
  import isqrt_seq_pkg::*;
#(
  parameter int BW_CNT = BW_CNT_DEF,
  parameter int BW_RAD = BW_RAD_DEF
) (
  input  logic                       clk,
  input  logic                       rstx,
  input  logic                       start,
  input  logic [BW_RAD-1:0]          rad,
  output logic [bw_root(BW_RAD)-1:0] root,
  output logic [bw_root(BW_RAD):0]   rem,
  output logic                       busy,
  output logic                       done,
  output state_e                     dbg_state
);

  localparam int N = bw_root(BW_RAD);
  localparam logic [BW_CNT-1:0] CNT_INIT = BW_CNT'(N - 1);
  localparam logic [BW_CNT-1:0] CNT_ONE  = BW_CNT'(1);

  // Handshake: start (with rad) is taken on a rising edge only while busy=0;
  // start while busy=1 is dropped. done pulses for one cycle with busy=0, and
  // root/rem then hold until the next accepted start.

  state_e            state_q, state_d;
  logic [BW_RAD-1:0] rsh_q, rsh_d;
  logic [N-1:0]      q_q, q_d;
  logic [N:0]        r_q, r_d;
  logic [BW_CNT-1:0] cnt_q, cnt_d;
  logic              done_q, done_d;

  logic [N:0]        step_r;
  logic [N-1:0]      step_q;

  isqrt_step #(
    .BW_RAD (BW_RAD)
  ) u_step (
    .r        (r_q),
    .q        (q_q),
    .rad_bits (rsh_q[BW_RAD-1 -: 2]),
    .r_nxt    (step_r),
    .q_nxt    (step_q)
  );

  always_comb begin
    state_d = state_q;
    rsh_d   = rsh_q;
    q_d     = q_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          rsh_d   = rad;
          q_d     = '0;
          r_d     = '0;
          cnt_d   = CNT_INIT;
        end
      end
      RUN: begin
        q_d   = step_q;
        r_d   = step_r;
        rsh_d = rsh_q << 2;
        if (cnt_q == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstx) begin
    if (!rstx) begin
      state_q <= IDLE;
      rsh_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rsh_q   <= rsh_d;
      q_q     <= q_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign root      = q_q;
  assign rem       = r_q;
  assign busy      = (state_q == RUN);
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_isqrt_seq.sv
// Self-checking bench for isqrt_seq: directed edge cases, handshake scenarios
// and exhaustive sweeps at three radicand widths against an arithmetic model.
module tb_isqrt_seq;
  import isqrt_seq_pkg::*;

  logic clk;
  logic rstx;

  logic       start8;
  logic [7:0] rad8;
  logic [3:0] root8;
  logic [4:0] rem8;
  logic       busy8, done8;
  state_e     st8;

  logic       start2;
  logic [1:0] rad2;
  logic [0:0] root2;
  logic [1:0] rem2;
  logic       busy2, done2;
  state_e     st2;

  logic       start10;
  logic [9:0] rad10;
  logic [4:0] root10;
  logic [5:0] rem10;
  logic       busy10, done10;
  state_e     st10;

  int checks;
  int errors;
  logic [8:0] exp_q[$];

  isqrt_seq #(.BW_CNT(3), .BW_RAD(8)) dut (
    .clk(clk), .rstx(rstx), .start(start8), .rad(rad8), .root(root8),
    .rem(rem8), .busy(busy8), .done(done8), .dbg_state(st8)
  );

  isqrt_seq #(.BW_CNT(3), .BW_RAD(2)) dut2 (
    .clk(clk), .rstx(rstx), .start(start2), .rad(rad2), .root(root2),
    .rem(rem2), .busy(busy2), .done(done2), .dbg_state(st2)
  );

  isqrt_seq #(.BW_CNT(3), .BW_RAD(10)) dut10 (
    .clk(clk), .rstx(rstx), .start(start10), .rad(rad10), .root(root10),
    .rem(rem10), .busy(busy10), .done(done10), .dbg_state(st10)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int model_root(input int v);
    int r;
    r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction

  function automatic int model_rem(input int v);
    int r;
    r = model_root(v);
    return v - r * r;
  endfunction

  // ---------------- drivers ----------------
  // cyc = 1 at the first falling edge after the accepting rising edge.
  task automatic op8(input int v, output int cyc, output logic to);
    @(negedge clk);
    start8 = 1'b1;
    rad8   = v[7:0];
    @(negedge clk);
    start8 = 1'b0;
    rad8   = 8'($urandom_range(0, 255));
    cyc = 1;
    while (!done8 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    to = !done8;
  endtask

  task automatic op2(input int v, output int cyc, output logic to);
    @(negedge clk);
    start2 = 1'b1;
    rad2   = v[1:0];
    @(negedge clk);
    start2 = 1'b0;
    cyc = 1;
    while (!done2 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    to = !done2;
  endtask

  task automatic op10(input int v, output int cyc, output logic to);
    @(negedge clk);
    start10 = 1'b1;
    rad10   = v[9:0];
    @(negedge clk);
    start10 = 1'b0;
    cyc = 1;
    while (!done10 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    to = !done10;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rstx = 1'b0;
    #12;
    checks++;
    if ({root8, rem8, busy8, done8} !== 11'd0 || st8 !== IDLE) begin
      errors++;
      $display("FAIL reset_w8: root=%0d rem=%0d busy=%b done=%b state=%0d, want all 0",
               root8, rem8, busy8, done8, st8);
    end
    checks++;
    if ({root2, rem2, busy2, done2} !== 5'd0 || {root10, rem10, busy10, done10} !== 13'd0) begin
      errors++;
      $display("FAIL reset_w2_w10: w2=%h w10=%h, want 0",
               {root2, rem2, busy2, done2}, {root10, rem10, busy10, done10});
    end
    @(negedge clk);
    rstx = 1'b1;
  endtask

  task automatic test_edges();
    int   vals[5];
    int   cyc;
    logic to;
    vals = '{0, 1, 255, 144, 143};
    foreach (vals[i]) begin
      op8(vals[i], cyc, to);
      checks++;
      if (to || cyc != 5) begin
        errors++;
        $display("FAIL edge_latency rad=%0d: done at cycle %0d (timeout=%b), want 5",
                 vals[i], cyc, to);
      end
      checks++;
      if (root8 !== 4'(model_root(vals[i])) || rem8 !== 5'(model_rem(vals[i])) || busy8 !== 1'b0) begin
        errors++;
        $display("FAIL edge_result rad=%0d: got %0d/%0d busy=%b, want %0d/%0d busy=0",
                 vals[i], root8, rem8, busy8, model_root(vals[i]), model_rem(vals[i]));
      end
    end
  endtask

  task automatic test_random();
    int   v, cyc;
    logic to;
    for (int i = 0; i < 40; i++) begin
      v = $urandom_range(0, 255);
      op8(v, cyc, to);
      checks++;
      if (to || root8 !== 4'(model_root(v)) || rem8 !== 5'(model_rem(v))) begin
        errors++;
        $display("FAIL random rad=%0d: got %0d/%0d (timeout=%b), want %0d/%0d",
                 v, root8, rem8, to, model_root(v), model_rem(v));
      end
    end
  endtask

  task automatic test_ignored_start();
    int ndone, first;
    logic busy_late;
    ndone = 0;
    first = 0;
    busy_late = 1'b0;
    @(negedge clk);
    start8 = 1'b1;
    rad8   = 8'd100;
    @(negedge clk);
    start8 = 1'b0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      if (done8) begin
        ndone++;
        if (first == 0) first = cyc;
      end
      if (cyc >= 5 && busy8) busy_late = 1'b1;
      if (cyc == 2) begin
        start8 = 1'b1;
        rad8   = 8'd9;
      end else begin
        start8 = 1'b0;
      end
      @(negedge clk);
    end
    checks++;
    if (ndone != 1 || first != 5 || busy_late) begin
      errors++;
      $display("FAIL ignored_start_timing: dones=%0d first=%0d busy_late=%b, want 1/5/0",
               ndone, first, busy_late);
    end
    checks++;
    if (root8 !== 4'd10 || rem8 !== 5'd0) begin
      errors++;
      $display("FAIL ignored_start_result: got %0d/%0d, want 10/0", root8, rem8);
    end
  endtask

  task automatic test_back_to_back();
    int   cyc;
    logic to;
    op8(36, cyc, to);
    checks++;
    if (to || root8 !== 4'd6 || rem8 !== 5'd0) begin
      errors++;
      $display("FAIL b2b_first: got %0d/%0d (timeout=%b), want 6/0", root8, rem8, to);
    end
    start8 = 1'b1;
    rad8   = 8'd49;
    @(negedge clk);
    start8 = 1'b0;
    cyc = 1;
    while (!done8 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (!done8 || cyc != 5 || root8 !== 4'd7 || rem8 !== 5'd0) begin
      errors++;
      $display("FAIL b2b_second: done=%b cycle=%0d got %0d/%0d, want done at 5 with 7/0",
               done8, cyc, root8, rem8);
    end
  endtask

  task automatic test_reset_mid_op();
    int   cyc;
    logic to;
    @(negedge clk);
    start8 = 1'b1;
    rad8   = 8'd200;
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    rstx = 1'b0;
    #1;
    checks++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 || root8 !== 4'd0 || rem8 !== 5'd0 || st8 !== IDLE) begin
      errors++;
      $display("FAIL reset_mid_op: busy=%b done=%b root=%0d rem=%0d state=%0d, want all 0",
               busy8, done8, root8, rem8, st8);
    end
    @(negedge clk);
    rstx = 1'b1;
    op8(200, cyc, to);
    checks++;
    if (to || cyc != 5 || root8 !== 4'd14 || rem8 !== 5'd4) begin
      errors++;
      $display("FAIL reset_rerun: cycle=%0d got %0d/%0d (timeout=%b), want 14/4 at 5",
               cyc, root8, rem8, to);
    end
  endtask

  task automatic test_sweep8();
    int   cyc;
    logic to;
    logic [8:0] exp;
    int   r, m;
    for (int v = 0; v < 256; v++) begin
      exp_q.push_back({4'(model_root(v)), 5'(model_rem(v))});
      op8(v, cyc, to);
      exp = exp_q.pop_front();
      r = int'(root8);
      m = int'(rem8);
      checks++;
      if (to || {root8, rem8} !== exp || r * r + m != v || m > 2 * r) begin
        errors++;
        $display("FAIL sweep8 rad=%0d: got %0d/%0d (timeout=%b), want %0d/%0d",
                 v, root8, rem8, to, exp[8:5], exp[4:0]);
      end
    end
  endtask

  task automatic test_sweep2();
    int   cyc, r, m;
    logic to;
    for (int v = 0; v < 4; v++) begin
      op2(v, cyc, to);
      r = int'(root2);
      m = int'(rem2);
      checks++;
      if (to || cyc != 2 || r != model_root(v) || r * r + m != v || m > 2 * r) begin
        errors++;
        $display("FAIL sweep2 rad=%0d: got %0d/%0d at cycle %0d (timeout=%b), want %0d/%0d at 2",
                 v, r, m, cyc, to, model_root(v), model_rem(v));
      end
    end
  endtask

  task automatic test_sweep10();
    int   cyc, r, m;
    logic to;
    for (int v = 0; v < 1024; v++) begin
      op10(v, cyc, to);
      r = int'(root10);
      m = int'(rem10);
      checks++;
      if (to || cyc != 6 || r != model_root(v) || r * r + m != v || m > 2 * r) begin
        errors++;
        $display("FAIL sweep10 rad=%0d: got %0d/%0d at cycle %0d (timeout=%b), want %0d/%0d at 6",
                 v, r, m, cyc, to, model_root(v), model_rem(v));
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    checks  = 0;
    errors  = 0;
    start8  = 1'b0;
    rad8    = '0;
    start2  = 1'b0;
    rad2    = '0;
    start10 = 1'b0;
    rad10   = '0;
    test_reset();
    test_edges();
    test_random();
    test_ignored_start();
    test_back_to_back();
    test_reset_mid_op();
    test_sweep8();
    test_sweep2();
    test_sweep10();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
